// File: rtl/vai_c0_req_arb.sv
// rtl/vai_c0_req_arb.sv - round-robin c0 read-request arbiter with vmid relocation and response routing
// Optional per-vmid grant counters are enabled with VAI_ARB_STATS_EN.
module vai_c0_req_arb #(
  parameter int NUM_SUB_AFUS = 8,
  parameter int ADDR_W       = 42,
  parameter int MDATA_W      = 16
) (
  input  logic                               pClk,
  input  logic                               pck_cp2af_softReset_n,
  input  logic [NUM_SUB_AFUS-1:0]            req_valid,
  output logic [NUM_SUB_AFUS-1:0]            req_ready,
  input  logic [NUM_SUB_AFUS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_SUB_AFUS*MDATA_W-1:0]    req_mdata,
  input  logic [NUM_SUB_AFUS*64-1:0]         offset_array,
  input  logic [63:0]                        sub_afu_reset,
  input  logic                               tx_almfull,
  output logic                               tx_valid,
  output logic [ADDR_W-1:0]                  tx_addr,
  output logic [MDATA_W-1:0]                 tx_mdata,
  input  logic                               rx_valid,
  input  logic [MDATA_W-1:0]                 rx_mdata,
  output logic [NUM_SUB_AFUS-1:0]            rsp_valid,
  output logic [MDATA_W-1:0]                 rsp_mdata,
  input  logic [$clog2(NUM_SUB_AFUS)-1:0]    stat_sel,
  output logic [31:0]                        stat_count
);
  localparam int N      = NUM_SUB_AFUS;
  localparam int VMID_W = $clog2(NUM_SUB_AFUS);

  logic [N-1:0]         sar;
  logic [ADDR_W-1:0]    req_addr_a   [N];
  logic [MDATA_W-1:0]   req_mdata_a  [N];
  logic [ADDR_W-1:0]    offset_a     [N];

  logic [N-1:0]         held_q, held_d;
  logic [ADDR_W-1:0]    held_addr_q  [N];
  logic [ADDR_W-1:0]    held_addr_d  [N];
  logic [MDATA_W-1:0]   held_mdata_q [N];
  logic [MDATA_W-1:0]   held_mdata_d [N];
  logic [VMID_W-1:0]    last_grant_q, last_grant_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [ADDR_W-1:0]    tx_addr_q, tx_addr_d;
  logic [MDATA_W-1:0]   tx_mdata_q, tx_mdata_d;
  logic [N-1:0]         rsp_valid_q, rsp_valid_d;
  logic [MDATA_W-1:0]   rsp_mdata_q, rsp_mdata_d;

  logic [N-1:0]         eligible;
  logic                 gnt_found;
  logic [VMID_W-1:0]    gnt_idx;
  logic [VMID_W-1:0]    cand;
  logic [VMID_W-1:0]    rx_vmid;
  logic                 unused_ok;

  assign sar       = sub_afu_reset[N-1:0];
  assign unused_ok = ^{sub_afu_reset, offset_array, stat_sel};

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign req_addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign req_mdata_a[i] = req_mdata[i*MDATA_W +: MDATA_W];
    assign offset_a[i]    = offset_array[i*64 +: ADDR_W];
  end

  assign req_ready = ~held_q & ~sar;
  assign eligible  = held_q & ~sar;

  // Search upward from last_grant+1; the VMID_W-bit add wraps modulo N.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = last_grant_q + VMID_W'(k);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (tx_almfull) gnt_found = 1'b0;
  end

  always_comb begin
    held_d       = held_q;
    held_addr_d  = held_addr_q;
    held_mdata_d = held_mdata_q;
    last_grant_d = last_grant_q;
    tx_valid_d   = 1'b0;
    tx_addr_d    = tx_addr_q;
    tx_mdata_d   = tx_mdata_q;
    if (gnt_found) begin
      tx_valid_d      = 1'b1;
      tx_addr_d       = held_addr_q[gnt_idx] + offset_a[gnt_idx];
      tx_mdata_d      = {gnt_idx, held_mdata_q[gnt_idx][MDATA_W-VMID_W-1:0]};
      held_d[gnt_idx] = 1'b0;
      last_grant_d    = gnt_idx;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        held_d[i]       = 1'b1;
        held_addr_d[i]  = req_addr_a[i];
        held_mdata_d[i] = req_mdata_a[i];
      end
      if (sar[i]) held_d[i] = 1'b0;
    end
  end

  // Responses for a vmid under sub-AFU reset are dropped here.
  always_comb begin
    rx_vmid     = rx_mdata[MDATA_W-1 -: VMID_W];
    rsp_valid_d = '0;
    if (rx_valid) rsp_valid_d[rx_vmid] = ~sar[rx_vmid];
    rsp_mdata_d = rx_mdata;
    rsp_mdata_d[MDATA_W-1 -: VMID_W] = '0;
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      held_q       <= '0;
      last_grant_q <= VMID_W'(N - 1);
      tx_valid_q   <= 1'b0;
      tx_addr_q    <= '0;
      tx_mdata_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_mdata_q  <= '0;
      for (int i = 0; i < N; i++) begin
        held_addr_q[i]  <= '0;
        held_mdata_q[i] <= '0;
      end
    end else begin
      held_q       <= held_d;
      held_addr_q  <= held_addr_d;
      held_mdata_q <= held_mdata_d;
      last_grant_q <= last_grant_d;
      tx_valid_q   <= tx_valid_d;
      tx_addr_q    <= tx_addr_d;
      tx_mdata_q   <= tx_mdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_mdata_q  <= rsp_mdata_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_addr   = tx_addr_q;
  assign tx_mdata  = tx_mdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_mdata = rsp_mdata_q;

`ifdef VAI_ARB_STATS_EN
  logic [31:0] cnt_q [N];
  logic [31:0] cnt_d [N];
  logic [31:0] stat_count_q, stat_count_d;

  always_comb begin
    cnt_d = cnt_q;
    if (gnt_found) cnt_d[gnt_idx] = cnt_q[gnt_idx] + 32'd1;
    for (int i = 0; i < N; i++) begin
      if (sar[i]) cnt_d[i] = '0;
    end
    stat_count_d = cnt_q[stat_sel];
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      stat_count_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      stat_count_q <= stat_count_d;
      cnt_q        <= cnt_d;
    end
  end

  assign stat_count = stat_count_q;
`else
  assign stat_count = 32'd0;
`endif

endmodule

// File: tb/tb_vai_c0_req_arb.sv
// tb/tb_vai_c0_req_arb.sv - scoreboard bench for vai_c0_req_arb with a behavioural arbitration model
module tb_vai_c0_req_arb;
  localparam int N  = 8;
  localparam int AW = 42;
  localparam int MW = 16;
  localparam int VW = 3;

  logic              pClk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*MW-1:0]   req_mdata = '0;
  logic [N*64-1:0]   offset_array = '0;
  logic [63:0]       sub_afu_reset = '0;
  logic              tx_almfull = 1'b0;
  logic              tx_valid;
  logic [AW-1:0]     tx_addr;
  logic [MW-1:0]     tx_mdata;
  logic              rx_valid = 1'b0;
  logic [MW-1:0]     rx_mdata = '0;
  logic [N-1:0]      rsp_valid;
  logic [MW-1:0]     rsp_mdata;
  logic [VW-1:0]     stat_sel = '0;
  logic [31:0]       stat_count;

  vai_c0_req_arb dut (
    .pClk(pClk), .pck_cp2af_softReset_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_mdata(req_mdata),
    .offset_array(offset_array), .sub_afu_reset(sub_afu_reset), .tx_almfull(tx_almfull),
    .tx_valid(tx_valid), .tx_addr(tx_addr), .tx_mdata(tx_mdata),
    .rx_valid(rx_valid), .rx_mdata(rx_mdata), .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata),
    .stat_sel(stat_sel), .stat_count(stat_count)
  );

  always #5 pClk = ~pClk;

  typedef struct { logic [AW-1:0] addr; logic [MW-1:0] mdata; int cyc; } tx_t;
  typedef struct { logic [N-1:0] vec; logic [MW-1:0] mdata; int cyc; } rs_t;

  tx_t           txq[$];
  rs_t           rsq[$];
  int            glog_v[$];
  int            glog_c[$];
  int            rsp_seen = 0;
  logic [AW-1:0] last_addr = '0;
  logic [MW-1:0] last_md = '0;
  int            last_cyc = 0;
  int            cyc = 0;
  int            nvec = 0;
  int            nerr = 0;

  bit            m_held[N];
  logic [AW-1:0] m_addr[N];
  logic [MW-1:0] m_md[N];
  int            m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    tx_t e;
    rs_t r;
    forever begin
      @(posedge pClk);
      cyc++;
      #1;
      if (tx_valid) begin
        glog_v.push_back(int'(tx_mdata[MW-1 -: VW]));
        glog_c.push_back(cyc);
        last_addr = tx_addr; last_md = tx_mdata; last_cyc = cyc;
        if (txq.size() == 0) chk("tx_unexpected", tx_valid, 1'b0);
        else begin
          e = txq.pop_front();
          chk("tx_cycle", cyc, e.cyc);
          chk("tx_addr", tx_addr, e.addr);
          chk("tx_mdata", tx_mdata, e.mdata);
        end
      end else if (txq.size() > 0 && txq[0].cyc <= cyc) begin
        chk("tx_missing", tx_valid, 1'b1);
        e = txq.pop_front();
      end
      if (|rsp_valid) begin
        rsp_seen++;
        if (rsq.size() == 0) chk("rsp_unexpected", rsp_valid, '0);
        else begin
          r = rsq.pop_front();
          chk("rsp_cycle", cyc, r.cyc);
          chk("rsp_valid", rsp_valid, r.vec);
          chk("rsp_mdata", rsp_mdata, r.mdata);
        end
      end else if (rsq.size() > 0 && rsq[0].cyc <= cyc) begin
        chk("rsp_missing", rsp_valid, rsq[0].vec);
        r = rsq.pop_front();
      end
    end
  end

  task automatic clear_inputs();
    req_valid = '0; tx_almfull = 1'b0; sub_afu_reset = '0;
    rx_valid = 1'b0; rx_mdata = '0; stat_sel = '0;
  endtask

  task automatic clear_logs();
    glog_v.delete(); glog_c.delete(); rsp_seen = 0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [MW-1:0] m);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_mdata[i*MW +: MW] = m;
  endtask

  // One clock: check ready, predict grant/accept/response from the rules, advance to the next negedge.
  task automatic cycle();
    logic [N-1:0]  rdy;
    logic [N-1:0]  sar;
    logic [VW-1:0] v;
    int            g;
    tx_t           t;
    rs_t           r;
    #1;
    sar = sub_afu_reset[N-1:0];
    for (int i = 0; i < N; i++) rdy[i] = !m_held[i] && !sar[i];
    chk("req_ready", req_ready, rdy);
    g = -1;
    if (!tx_almfull) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (g < 0 && m_held[j] && !sar[j]) g = j;
      end
    end
    if (g >= 0) begin
      t.addr = m_addr[g] + offset_array[g*64 +: AW];
      v = VW'(g);
      t.mdata = {v, m_md[g][MW-VW-1:0]};
      t.cyc = cyc + 1;
      txq.push_back(t);
      m_held[g] = 1'b0;
      m_last = g;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && rdy[i]) begin
        m_held[i] = 1'b1;
        m_addr[i] = req_addr[i*AW +: AW];
        m_md[i]   = req_mdata[i*MW +: MW];
      end
      if (sar[i]) m_held[i] = 1'b0;
    end
    if (rx_valid) begin
      v = rx_mdata[MW-1 -: VW];
      if (!sar[v]) begin
        r.vec = '0; r.vec[v] = 1'b1;
        r.mdata = rx_mdata; r.mdata[MW-1 -: VW] = '0;
        r.cyc = cyc + 1;
        rsq.push_back(r);
      end
    end
    @(negedge pClk);
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    txq.delete(); rsq.delete();
    for (int i = 0; i < N; i++) m_held[i] = 1'b0;
    m_last = N - 1;
    repeat (2) @(negedge pClk);
    #1;
    chk("rst_req_ready", req_ready, {N{1'b1}});
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_addr", tx_addr, '0);
    chk("rst_tx_mdata", tx_mdata, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_mdata", rsp_mdata, '0);
    chk("rst_stat_count", stat_count, '0);
    rst_n = 1'b1;
    @(negedge pClk);
  endtask

  initial begin
    int c0;
    int bad;
    @(negedge pClk);
    do_reset();

    // Single requester with relocation.
    offset_array[2*64 +: 64] = 64'h1000;
    set_req(2, AW'(42'h100), MW'(16'h1abc));
    c0 = cyc;
    cycle();
    idle(4);
    chk("single_addr", last_addr, 42'h1100);
    chk("single_vmid", last_md[MW-1 -: VW], 3'd2);
    chk("single_latency", last_cyc - c0, 2);

    // Address wrap.
    offset_array[5*64 +: 64] = 64'h2;
    set_req(5, AW'(42'h3FF_FFFF_FFFF), MW'(16'h0055));
    cycle();
    idle(4);
    chk("wrap_addr", last_addr, 42'h1);

    // Fairness with all requesters continuously asserting.
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) set_req(i, AW'(i * 64), MW'(i));
    repeat (20) cycle();
    idle(12);
    chk("fair_count_ge17", glog_v.size() >= 17, 1'b1);
    for (int k = 0; k < 16 && k + 1 < glog_v.size(); k++) begin
      chk("fair_order", glog_v[k], k % N);
      chk("fair_gap", glog_c[k+1] - glog_c[k], 1);
    end

    // Backpressure: three slots held under almfull for five cycles.
    do_reset();
    clear_logs();
    tx_almfull = 1'b1;
    set_req(1, AW'(42'h10), MW'(16'h11));
    set_req(4, AW'(42'h40), MW'(16'h44));
    set_req(6, AW'(42'h60), MW'(16'h66));
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    tx_almfull = 1'b0;
    c0 = cyc;
    idle(6);
    chk("bp_count", glog_v.size(), 3);
    if (glog_v.size() == 3) begin
      chk("bp_first_cycle", glog_c[0], c0 + 1);
      chk("bp_second_cycle", glog_c[1], c0 + 2);
      chk("bp_third_cycle", glog_c[2], c0 + 3);
      chk("bp_order", {glog_v[0][3:0], glog_v[1][3:0], glog_v[2][3:0]}, 12'h146);
    end

    // Isolation of sub-AFU 3, with stray high reset bits that must be ignored.
    do_reset();
    clear_logs();
    tx_almfull = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, AW'(i * 16), MW'(16'h0100 + i));
    cycle();
    req_valid = '0;
    tx_almfull = 1'b0;
    sub_afu_reset = 64'hF0F0_0000_0000_0008;
    rx_valid = 1'b1;
    rx_mdata = {3'd3, 13'h0abc};
    cycle();
    rx_valid = 1'b0;
    repeat (12) cycle();
    sub_afu_reset = '0;
    idle(3);
    chk("iso_grants", glog_v.size(), N - 1);
    bad = 0;
    foreach (glog_v[k]) if (glog_v[k] == 3) bad++;
    chk("iso_no_vmid3", bad, 0);
    chk("iso_rsp_dropped", rsp_seen, 0);

    // Reset mid-operation discards held requests; later responses still route.
    clear_logs();
    tx_almfull = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, AW'(i), MW'(i));
    cycle();
    do_reset();
    rx_valid = 1'b1;
    rx_mdata = {3'd6, 13'h1234};
    cycle();
    idle(10);
    chk("midrst_grants", glog_v.size(), 0);
    chk("midrst_rsp", rsp_seen, 1);

`ifdef VAI_ARB_STATS_EN
    do_reset();
    for (int n = 0; n < 10; n++) begin
      set_req(5, AW'(n), MW'(n));
      cycle();
      req_valid = '0;
      cycle();
    end
    idle(3);
    stat_sel = 3'd5;
    cycle();
    cycle();
    #1;
    chk("stat_count_10", stat_count, 32'd10);
    sub_afu_reset = 64'h20;
    stat_sel = 3'd5;
    cycle();
    sub_afu_reset = '0;
    stat_sel = 3'd5;
    cycle();
    cycle();
    #1;
    chk("stat_count_cleared", stat_count, 32'd0);
    @(negedge pClk);
`endif

    // Randomised traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0)
        for (int i = 0; i < N; i++) offset_array[i*64 +: 64] = {$urandom(), $urandom()};
      req_valid = N'($urandom());
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW] = AW'({$urandom(), $urandom()});
        req_mdata[i*MW +: MW] = MW'($urandom());
      end
      tx_almfull = ($urandom_range(3) == 0);
      sub_afu_reset = {$urandom(), $urandom()};
      sub_afu_reset[N-1:0] = ($urandom_range(9) == 0) ? N'(1 << $urandom_range(N - 1)) : '0;
      rx_valid = $urandom_range(1) == 1;
      rx_mdata = MW'($urandom());
      cycle();
    end
    idle(6);
`ifndef VAI_ARB_STATS_EN
    chk("stat_count_off", stat_count, '0);
`endif
    chk("txq_drained", txq.size(), 0);
    chk("rsq_drained", rsq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
